// File: rtl/d_e_forward_stage_pkg.sv
// d_e_forward_stage_pkg: shared widths, reset PC and encodings for the D/E boundary
package d_e_forward_stage_pkg;
    localparam int          DE_TW       = 2;
    localparam logic [31:0] DE_RESET_PC = 32'h0000_3000;
    localparam logic [1:0]  TUSE_NONE   = 2'd3;
    localparam logic [31:0] NOP         = 32'b0;
endpackage

// File: rtl/d_e_forward_stage_fwd_mux.sv
// d_e_forward_stage_fwd_mux: one operand's E/M/W forward select and hazard stall term
module d_e_forward_stage_fwd_mux
    import d_e_forward_stage_pkg::*;
#(
    parameter int TW = DE_TW
) (
    input  logic [4:0]    i_addr,
    input  logic [31:0]   i_grf,
    input  logic [TW-1:0] i_tuse,
    input  logic [4:0]    i_e_wa,
    input  logic [TW-1:0] i_e_tnew,
    input  logic [31:0]   i_e_wd,
    input  logic [4:0]    i_m_wa,
    input  logic [TW-1:0] i_m_tnew,
    input  logic [31:0]   i_m_wd,
    input  logic [4:0]    i_w_wa,
    input  logic          i_w_we,
    input  logic [31:0]   i_w_wd,
    output logic [31:0]   o_val,
    output logic          o_stall
);
    logic w_nz;
    logic w_e_hit;
    logic w_m_hit;
    logic w_w_hit;
    logic w_used;

    assign w_nz    = i_addr != 5'd0;
    assign w_e_hit = w_nz && i_addr == i_e_wa;
    assign w_m_hit = w_nz && i_addr == i_m_wa;
    assign w_w_hit = w_nz && i_w_we && i_addr == i_w_wa;
    assign w_used  = w_nz && i_tuse != TW'(TUSE_NONE);

    assign o_val = !w_nz                          ? 32'b0  :
                   (w_e_hit && i_e_tnew == '0)    ? i_e_wd :
                   (w_m_hit && i_m_tnew == '0)    ? i_m_wd :
                   w_w_hit                        ? i_w_wd : i_grf;

    // the youngest producer (E) alone decides the hazard when it targets this register
    assign o_stall = w_used && (w_e_hit ? i_e_tnew > i_tuse : (w_m_hit && i_m_tnew > i_tuse));
endmodule

// File: rtl/d_e_forward_stage.sv
// d_e_forward_stage: D-stage operand forwarding, Tuse/Tnew stall and D/E pipeline register
module d_e_forward_stage
    import d_e_forward_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DE_RESET_PC,
    parameter int          TW       = DE_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   D_pc,
    input  logic [31:0]   D_instr,
    input  logic [31:0]   D_imm32,
    input  logic [4:0]    D_rs_addr,
    input  logic [4:0]    D_rt_addr,
    input  logic [31:0]   D_rd1,
    input  logic [31:0]   D_rd2,
    input  logic [TW-1:0] D_tuse_rs,
    input  logic [TW-1:0] D_tuse_rt,
    input  logic [4:0]    D_wa,
    input  logic [TW-1:0] D_tnew,
    input  logic [31:0]   E_pre_wd,
    input  logic [4:0]    M_wa,
    input  logic [TW-1:0] M_tnew,
    input  logic [31:0]   M_wd,
    input  logic [4:0]    W_wa,
    input  logic          W_we,
    input  logic [31:0]   W_wd,
    output logic [31:0]   D_rs_fwd,
    output logic [31:0]   D_rt_fwd,
    output logic          stall,
    output logic [31:0]   E_pc,
    output logic [31:0]   E_instr,
    output logic [31:0]   E_imm32,
    output logic [31:0]   E_rs_val,
    output logic [31:0]   E_rt_val,
    output logic [4:0]    E_rs_addr,
    output logic [4:0]    E_rt_addr,
    output logic [4:0]    E_wa,
    output logic [TW-1:0] E_tnew
);
    logic w_rs_stall;
    logic w_rt_stall;

    d_e_forward_stage_fwd_mux #(.TW(TW)) u_rs (
        .i_addr(D_rs_addr), .i_grf(D_rd1), .i_tuse(D_tuse_rs),
        .i_e_wa(E_wa), .i_e_tnew(E_tnew), .i_e_wd(E_pre_wd),
        .i_m_wa(M_wa), .i_m_tnew(M_tnew), .i_m_wd(M_wd),
        .i_w_wa(W_wa), .i_w_we(W_we), .i_w_wd(W_wd),
        .o_val(D_rs_fwd), .o_stall(w_rs_stall)
    );

    d_e_forward_stage_fwd_mux #(.TW(TW)) u_rt (
        .i_addr(D_rt_addr), .i_grf(D_rd2), .i_tuse(D_tuse_rt),
        .i_e_wa(E_wa), .i_e_tnew(E_tnew), .i_e_wd(E_pre_wd),
        .i_m_wa(M_wa), .i_m_tnew(M_tnew), .i_m_wd(M_wd),
        .i_w_wa(W_wa), .i_w_we(W_we), .i_w_wd(W_wd),
        .o_val(D_rt_fwd), .o_stall(w_rt_stall)
    );

    assign stall = w_rs_stall | w_rt_stall;

    // D/E register: nop at RESET_PC on reset, bubble carrying D_pc on stall, else advance D
    always_ff @(posedge clk) begin
        if (reset) begin
            E_pc      <= RESET_PC;
            E_instr   <= NOP;
            E_imm32   <= 32'b0;
            E_rs_val  <= 32'b0;
            E_rt_val  <= 32'b0;
            E_rs_addr <= 5'd0;
            E_rt_addr <= 5'd0;
            E_wa      <= 5'd0;
            E_tnew    <= '0;
        end else if (stall) begin
            E_pc      <= D_pc;
            E_instr   <= NOP;
            E_imm32   <= 32'b0;
            E_rs_val  <= 32'b0;
            E_rt_val  <= 32'b0;
            E_rs_addr <= 5'd0;
            E_rt_addr <= 5'd0;
            E_wa      <= 5'd0;
            E_tnew    <= '0;
        end else begin
            E_pc      <= D_pc;
            E_instr   <= D_instr;
            E_imm32   <= D_imm32;
            E_rs_val  <= D_rs_fwd;
            E_rt_val  <= D_rt_fwd;
            E_rs_addr <= D_rs_addr;
            E_rt_addr <= D_rt_addr;
            E_wa      <= D_wa;
            E_tnew    <= D_tnew;
        end
    end
endmodule

// File: tb/tb_d_e_forward_stage.sv
// tb_d_e_forward_stage: directed and random checks of forwarding, stall and D/E register
module tb_d_e_forward_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_pc, D_instr, D_imm32, D_rd1, D_rd2, E_pre_wd, M_wd, W_wd;
    logic [4:0]  D_rs_addr, D_rt_addr, D_wa, M_wa, W_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, D_tnew, M_tnew;
    logic        W_we;
    logic [31:0] D_rs_fwd, D_rt_fwd, E_pc, E_instr, E_imm32, E_rs_val, E_rt_val;
    logic        stall;
    logic [4:0]  E_rs_addr, E_rt_addr, E_wa;
    logic [1:0]  E_tnew;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_instr, m_imm, m_rsv, m_rtv;
    logic [4:0]  m_rsa, m_rta, m_wa;
    logic [1:0]  m_tnew;

    d_e_forward_stage dut (
        .clk(clk), .reset(reset),
        .D_pc(D_pc), .D_instr(D_instr), .D_imm32(D_imm32),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_rd1(D_rd1), .D_rd2(D_rd2),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_wa(D_wa), .D_tnew(D_tnew),
        .E_pre_wd(E_pre_wd), .M_wa(M_wa), .M_tnew(M_tnew), .M_wd(M_wd),
        .W_wa(W_wa), .W_we(W_we), .W_wd(W_wd),
        .D_rs_fwd(D_rs_fwd), .D_rt_fwd(D_rt_fwd), .stall(stall),
        .E_pc(E_pc), .E_instr(E_instr), .E_imm32(E_imm32),
        .E_rs_val(E_rs_val), .E_rt_val(E_rt_val),
        .E_rs_addr(E_rs_addr), .E_rt_addr(E_rt_addr), .E_wa(E_wa), .E_tnew(E_tnew)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // newest available producer value for register a, from the model's view of E and the M/W inputs
    function automatic logic [31:0] exp_fwd(input logic [4:0] a, input logic [31:0] grf);
        if (a == 5'd0) return 32'b0;
        if (a == m_wa && m_tnew == 2'd0) return E_pre_wd;
        if (a == M_wa && M_tnew == 2'd0) return M_wd;
        if (W_we && a == W_wa) return W_wd;
        return grf;
    endfunction

    // operand needed sooner than its youngest pending producer delivers
    function automatic logic exp_haz(input logic [4:0] a, input logic [1:0] tuse);
        if (a == 5'd0 || tuse == 2'd3) return 1'b0;
        if (a == m_wa) return m_tnew > tuse;
        return a == M_wa && M_tnew > tuse;
    endfunction

    function automatic logic exp_stall();
        return exp_haz(D_rs_addr, D_tuse_rs) || exp_haz(D_rt_addr, D_tuse_rt);
    endfunction

    task automatic zero_in();
        reset = 1'b0; D_pc = 32'h0; D_instr = 32'h0; D_imm32 = 32'h0;
        D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_rd1 = 32'h0; D_rd2 = 32'h0;
        D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_wa = 5'd0; D_tnew = 2'd0;
        E_pre_wd = 32'h0; M_wa = 5'd0; M_tnew = 2'd0; M_wd = 32'h0;
        W_wa = 5'd0; W_we = 1'b0; W_wd = 32'h0;
    endtask

    task automatic check_d();
        chk("rs_fwd", D_rs_fwd, exp_fwd(D_rs_addr, D_rd1));
        chk("rt_fwd", D_rt_fwd, exp_fwd(D_rt_addr, D_rd2));
        chk("stall", {31'b0, stall}, {31'b0, exp_stall()});
    endtask

    task automatic check_e();
        chk("E_pc", E_pc, m_pc);
        chk("E_instr", E_instr, m_instr);
        chk("E_imm32", E_imm32, m_imm);
        chk("E_rs_val", E_rs_val, m_rsv);
        chk("E_rt_val", E_rt_val, m_rtv);
        chk("E_rs_addr", {27'b0, E_rs_addr}, {27'b0, m_rsa});
        chk("E_rt_addr", {27'b0, E_rt_addr}, {27'b0, m_rta});
        chk("E_wa", {27'b0, E_wa}, {27'b0, m_wa});
        chk("E_tnew", {30'b0, E_tnew}, {30'b0, m_tnew});
    endtask

    // one posedge: the model's E takes reset, a bubble, or the D instruction, then E is compared
    task automatic tick();
        logic        st;
        logic [31:0] rsv, rtv;
        st  = exp_stall();
        rsv = exp_fwd(D_rs_addr, D_rd1);
        rtv = exp_fwd(D_rt_addr, D_rd2);
        @(posedge clk);
        #1;
        if (reset || st) begin
            m_pc = reset ? 32'h0000_3000 : D_pc;
            m_instr = 32'h0; m_imm = 32'h0; m_rsv = 32'h0; m_rtv = 32'h0;
            m_rsa = 5'd0; m_rta = 5'd0; m_wa = 5'd0; m_tnew = 2'd0;
        end else begin
            m_pc = D_pc; m_instr = D_instr; m_imm = D_imm32; m_rsv = rsv; m_rtv = rtv;
            m_rsa = D_rs_addr; m_rta = D_rt_addr; m_wa = D_wa; m_tnew = D_tnew;
        end
        check_e();
    endtask

    initial begin
        m_pc = 32'h0; m_instr = 32'h0; m_imm = 32'h0; m_rsv = 32'h0; m_rtv = 32'h0;
        m_rsa = 5'd0; m_rta = 5'd0; m_wa = 5'd0; m_tnew = 2'd0;
        zero_in();
        reset = 1'b1;
        @(negedge clk);
        tick();
        chk("t1_pc", E_pc, 32'h0000_3000);
        chk("t1_instr", E_instr, 32'h0);
        chk("t1_stall", {31'b0, stall}, 32'h0);
        reset = 1'b0;
        M_wa = 5'd5; M_tnew = 2'd0; M_wd = 32'h1234;
        D_rs_addr = 5'd5; D_rd1 = 32'h0; D_tuse_rs = 2'd1; D_pc = 32'h3004;
        #1;
        check_d();
        chk("t2_fwd", D_rs_fwd, 32'h1234);
        chk("t2_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("t2_erv", E_rs_val, 32'h1234);
        zero_in();
        D_pc = 32'h3008; D_instr = 32'h8c08_0000; D_wa = 5'd8; D_tnew = 2'd2;
        tick();
        zero_in();
        D_pc = 32'h300c; D_instr = 32'h1100_0004; D_rs_addr = 5'd8; D_tuse_rs = 2'd0;
        #1;
        check_d();
        chk("t3_stall", {31'b0, stall}, 32'h1);
        tick();
        chk("t3_bub_pc", E_pc, 32'h300c);
        chk("t3_bub_instr", E_instr, 32'h0);
        M_wa = 5'd8; M_tnew = 2'd1; M_wd = 32'h5555;
        #1;
        check_d();
        chk("t3_mstall", {31'b0, stall}, 32'h1);
        tick();
        M_tnew = 2'd0;
        #1;
        check_d();
        chk("t3_release", {31'b0, stall}, 32'h0);
        chk("t3_mfwd", D_rs_fwd, 32'h5555);
        tick();
        zero_in();
        D_pc = 32'h3010; D_wa = 5'd3; D_tnew = 2'd0;
        tick();
        E_pre_wd = 32'hA; M_wa = 5'd3; M_tnew = 2'd0; M_wd = 32'hB;
        W_wa = 5'd3; W_we = 1'b1; W_wd = 32'hC; D_rs_addr = 5'd3; D_tuse_rs = 2'd0;
        D_rd1 = 32'hDEAD; D_wa = 5'd0;
        #1;
        check_d();
        chk("t4_e", D_rs_fwd, 32'hA);
        tick();
        #1;
        check_d();
        chk("t4_m", D_rs_fwd, 32'hB);
        M_wa = 5'd0;
        #1;
        check_d();
        chk("t4_w", D_rs_fwd, 32'hC);
        zero_in();
        W_we = 1'b1; W_wd = 32'hFFFF; D_rs_addr = 5'd0; D_tuse_rs = 2'd0; D_rd1 = 32'h77;
        #1;
        check_d();
        chk("t5_zero", D_rs_fwd, 32'h0);
        chk("t5_stall", {31'b0, stall}, 32'h0);
        tick();
        zero_in();
        D_pc = 32'h3020; D_wa = 5'd9; D_tnew = 2'd3;
        tick();
        zero_in();
        D_pc = 32'h4444; D_rs_addr = 5'd9; D_tuse_rs = 2'd0;
        #1;
        chk("t6_stall", {31'b0, stall}, 32'h1);
        reset = 1'b1;
        tick();
        chk("t6_pc", E_pc, 32'h0000_3000);
        chk("t6_wa", {27'b0, E_wa}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            D_pc = $urandom; D_instr = $urandom; D_imm32 = $urandom;
            D_rs_addr = 5'($urandom_range(0, 7)); D_rt_addr = 5'($urandom_range(0, 7));
            D_rd1 = $urandom; D_rd2 = $urandom;
            D_tuse_rs = 2'($urandom_range(0, 3)); D_tuse_rt = 2'($urandom_range(0, 3));
            D_wa = 5'($urandom_range(0, 7)); D_tnew = 2'($urandom_range(0, 3));
            E_pre_wd = $urandom; M_wa = 5'($urandom_range(0, 7));
            M_tnew = 2'($urandom_range(0, 3)); M_wd = $urandom;
            W_wa = 5'($urandom_range(0, 7)); W_we = 1'($urandom_range(0, 1)); W_wd = $urandom;
            #1;
            check_d();
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
